// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Groups the two writeback requester handshakes that share the register
// file write port.
//   req0_* : ALU writeback requester (valid/addr/data in, ready back)
//   req1_* : load writeback requester (valid/addr/data in, ready back)
// Modports:
//   master : requester side, drives valid/addr/data and samples ready
//   slave  : arbiter side, samples valid/addr/data and drives ready
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the single write port of the register file. After reset it clears
// every register with zero, then shares the port round-robin between two
// writeback requesters and counts the writes it issues (saturating).
// Ports:
//   clock      : system clock
//   reset      : synchronous, active-low reset
//   io         : requester handshakes (slave modport)
//   RegWrite   : register file write enable (registered)
//   WriteReg   : register file write address (registered)
//   WriteData  : register file write data (registered)
//   init_done  : high once the clear sequence has finished
//   wr_count   : saturating count of writes issued after init
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int NUM_REGS    = 32,
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 32,
   parameter int ZERO_REG_RO = 1,
   parameter int CNT_W       = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   regfile_write_arbiter_if.slave io,
   output logic                  RegWrite,
   output logic [ADDR_W-1:0]     WriteReg,
   output logic [DATA_W-1:0]     WriteData,
   output logic                  init_done,
   output logic [CNT_W-1:0]      wr_count
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [ADDR_W-1:0] LastReg    = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W:0]   NumRegsExt = (ADDR_W + 1)'(NUM_REGS);

   state_t            state;
   logic [ADDR_W-1:0] initCnt;
   logic              rrPtr;
   logic              grant0;
   logic              grant1;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selData;
   logic              addrOk;
   logic              issue;

   // Grant selection. Readys are held low until the clear sequence is done
   // and while reset is asserted, so no handshake can complete in a cycle
   // whose write would be discarded by reset. Under contention rrPtr picks
   // the winner, otherwise the lone requester wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset && init_done) begin
         if (io.req0_valid && (!io.req1_valid || !rrPtr))
            grant0 = 1'b1;
         else if (io.req1_valid)
            grant1 = 1'b1;
      end
      selAddr = grant1 ? io.req1_addr : io.req0_addr;
      selData = grant1 ? io.req1_data : io.req0_data;
      addrOk  = ({1'b0, selAddr} < NumRegsExt) &&
                !((ZERO_REG_RO != 0) && (selAddr == '0));
      issue   = (grant0 || grant1) && addrOk;
   end

   assign io.req0_ready = grant0;
   assign io.req1_ready = grant1;

   // Main sequencer. INIT walks the address range writing zeros; RUN forwards
   // the granted request to the register file one cycle later. Dropped
   // requests (register 0 or out of range) still complete their handshake
   // and still move the round-robin pointer, but leave WriteReg/WriteData
   // holding their previous values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= INIT;
         initCnt   <= '0;
         rrPtr     <= 1'b0;
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
         init_done <= 1'b0;
         wr_count  <= '0;
      end else begin
         case (state)
            INIT: begin
               RegWrite  <= 1'b1;
               WriteReg  <= initCnt;
               WriteData <= '0;
               initCnt   <= initCnt + ADDR_W'(1);
               if (initCnt == LastReg)
                  state <= RUN;
            end
            RUN: begin
               init_done <= 1'b1;
               RegWrite  <= issue;
               if (grant0)
                  rrPtr <= 1'b1;
               else if (grant1)
                  rrPtr <= 1'b0;
               if (issue) begin
                  WriteReg  <= selAddr;
                  WriteData <= selData;
                  if (wr_count != '1)
                     wr_count <= wr_count + CNT_W'(1);
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter: clear sequence, single and
// contended requests, dropped writes, reset during clear and wr_count
// saturation (counter narrowed to 4 bits so saturation is reachable).
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic              clock;
   logic              reset;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic              init_done;
   logic [CNT_W-1:0]  wr_count;

   int total;
   int bad;

   regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) io ();

   regfile_write_arbiter #(
      .NUM_REGS(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .ZERO_REG_RO(1), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset), .io(io.slave),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .init_done(init_done), .wr_count(wr_count)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total = total + 1;
      if (observed !== expected) begin
         bad = bad + 1;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0,
                                input logic [DATA_W-1:0] d0, input logic v1,
                                input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      io.req0_valid = v0;
      io.req0_addr  = a0;
      io.req0_data  = d0;
      io.req1_valid = v1;
      io.req1_addr  = a1;
      io.req1_data  = d1;
      #1;
   endtask

   // Runs the full 32-write clear and checks it; req0 stays valid to show
   // readys are held low.
   task automatic checkClear(input string tag);
      applyStimulus(1'b1, 6'd9, 32'h9, 1'b0, '0, '0);
      for (int i = 0; i < 32; i++) begin
         tick();
         checkOutput({tag, "_we"},   {31'd0, RegWrite}, 32'd1);
         checkOutput({tag, "_addr"}, {26'd0, WriteReg}, i);
         checkOutput({tag, "_data"}, WriteData, 32'd0);
         checkOutput({tag, "_done"}, {31'd0, init_done}, 32'd0);
         checkOutput({tag, "_rdy0"}, {31'd0, io.req0_ready}, 32'd0);
      end
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      checkOutput({tag, "_we_end"}, {31'd0, RegWrite}, 32'd0);
      checkOutput({tag, "_done_rise"}, {31'd0, init_done}, 32'd1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      tick();
      checkOutput("rst_we",    {31'd0, RegWrite}, 32'd0);
      checkOutput("rst_addr",  {26'd0, WriteReg}, 32'd0);
      checkOutput("rst_data",  WriteData, 32'd0);
      checkOutput("rst_done",  {31'd0, init_done}, 32'd0);
      checkOutput("rst_count", {28'd0, wr_count}, 32'd0);

      reset = 1'b1;
      checkClear("init");

      // Single request from req0, granted combinationally.
      applyStimulus(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, '0, '0);
      checkOutput("r0_rdy0", {31'd0, io.req0_ready}, 32'd1);
      checkOutput("r0_rdy1", {31'd0, io.req1_ready}, 32'd0);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("r0_we",    {31'd0, RegWrite}, 32'd1);
      checkOutput("r0_addr",  {26'd0, WriteReg}, 32'd5);
      checkOutput("r0_data",  WriteData, 32'hDEADBEEF);
      checkOutput("r0_count", {28'd0, wr_count}, 32'd1);

      // req1 to register 0: accepted but dropped; pointer returns to req0.
      applyStimulus(1'b0, '0, '0, 1'b1, 6'd0, 32'hFFFFFFFF);
      checkOutput("z_rdy1", {31'd0, io.req1_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("z_we",    {31'd0, RegWrite}, 32'd0);
      checkOutput("z_count", {28'd0, wr_count}, 32'd1);
      checkOutput("z_hold",  {26'd0, WriteReg}, 32'd5);

      // Contention: alternate req0, req1, req0, req1.
      applyStimulus(1'b1, 6'd3, 32'h11, 1'b1, 6'd4, 32'h22);
      for (int c = 0; c < 4; c++) begin
         checkOutput("rr_rdy0", {31'd0, io.req0_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput("rr_rdy1", {31'd0, io.req1_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         checkOutput("rr_we",   {31'd0, RegWrite}, 32'd1);
         checkOutput("rr_addr", {26'd0, WriteReg}, (c % 2 == 0) ? 32'd3 : 32'd4);
         checkOutput("rr_data", WriteData, (c % 2 == 0) ? 32'h11 : 32'h22);
      end
      checkOutput("rr_count", {28'd0, wr_count}, 32'd5);

      // Out-of-range address: accepted, not issued, not counted.
      applyStimulus(1'b1, 6'd40, 32'h55, 1'b0, '0, '0);
      checkOutput("oor_rdy0", {31'd0, io.req0_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("oor_we",    {31'd0, RegWrite}, 32'd0);
      checkOutput("oor_count", {28'd0, wr_count}, 32'd5);

      // Reset during the clear, after the write to register 10.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      checkOutput("mid_addr10", {26'd0, WriteReg}, 32'd10);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checkOutput("mid_we",    {31'd0, RegWrite}, 32'd0);
      checkOutput("mid_addr",  {26'd0, WriteReg}, 32'd0);
      checkOutput("mid_count", {28'd0, wr_count}, 32'd0);
      checkClear("reinit");

      // Saturation of the 4-bit counter with back-to-back writes.
      applyStimulus(1'b1, 6'd7, 32'h77, 1'b0, '0, '0);
      for (int i = 1; i <= 18; i++) begin
         tick();
         checkOutput("sat_we",    {31'd0, RegWrite}, 32'd1);
         checkOutput("sat_count", {28'd0, wr_count}, (i < 15) ? i : 32'd15);
      end
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      checkOutput("sat_hold", {28'd0, wr_count}, 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
